// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// default frame geometry used by uart_rx.
package uart_pkg;

  // Default number of data bits per frame (LSB first on the line)
  localparam int DATA_BITS_DEF  = 8;

  // Default number of bd_tick pulses per bit period (even, >= 4)
  localparam int OVERSAMPLE_DEF = 16;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so that the idle-high line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Shift the raw line through two flops to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Detects a start edge, confirms it at mid-bit,
// samples DATA_BITS data bits LSB first at the centre of each bit, then checks
// the stop bit. A good frame loads data_out and raises data_valid until the
// consumer acknowledges; a bad stop bit pulses frame_err; a good frame landing
// on an unacknowledged word pulses overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bd_tick,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 stop_sample_s;
  logic                 frame_ok_s;
  logic                 frame_bad_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Flag the stop-bit mid sample and classify the frame it closes
  always_comb begin
    stop_sample_s = 1'b0;
    frame_ok_s    = 1'b0;
    frame_bad_s   = 1'b0;
    if (bd_tick && (state_r == STOP) && (tick_cnt_r == TICK_LAST)) begin
      stop_sample_s = 1'b1;
      frame_ok_s    = rx_s;
      frame_bad_s   = ~rx_s;
    end else begin
      stop_sample_s = 1'b0;
      frame_ok_s    = 1'b0;
      frame_bad_s   = 1'b0;
    end
  end

  // Frame sequencing: state, tick/bit counters and data shift register,
  // all advancing only on bd_tick so a missing tick freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
    end else if (bd_tick) begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r    <= START;
            tick_cnt_r <= TICK_ZERO;
          end else begin
            state_r    <= IDLE;
          end
        end
        START: begin
          if (tick_cnt_r == TICK_MID) begin
            // Mid start bit: a high line here was only a glitch
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            state_r    <= rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_r == TICK_LAST) begin
            // One full bit period after the previous mid point
            tick_cnt_r <= TICK_ZERO;
            shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= BIT_ZERO;
              state_r   <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_cnt_r == TICK_LAST) begin
            // Leave at mid stop bit so an immediate next start edge is caught
            tick_cnt_r <= TICK_ZERO;
            state_r    <= IDLE;
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= TICK_ZERO;
          bit_cnt_r  <= BIT_ZERO;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Consumer-facing outputs: word, valid flag and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= {DATA_BITS{1'b0}};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (frame_ok_s) begin
        // New word wins; an ack in this same cycle consumes the old word
        data_out   <= shift_r;
        data_valid <= 1'b1;
        overrun    <= data_valid & ~data_ack;
      end else begin
        if (frame_bad_s) begin
          frame_err <= 1'b1;
        end else begin
          frame_err <= 1'b0;
        end
        if (data_ack) begin
          data_valid <= 1'b0;
        end else begin
          data_valid <= data_valid;
        end
      end
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios for the key frame cases
// followed by random frames, all compared against a frame-level model.
module tb_uart_rx;

  localparam int BIT_CLK   = 64;            // 16 ticks x 4 clk
  localparam int FRAME_CLK = 10 * BIT_CLK;  // start + 8 data + stop

  logic       clk = 1'b0;
  logic       rst;
  logic       bd_tick;
  logic       rx;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  int cyc      = 0;
  int n_cmp    = 0;
  int n_mis    = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int rise_idx = -1;

  // Frame-level reference model
  logic [7:0] exp_data;
  logic       exp_valid;
  int         exp_ferr;
  int         exp_ovr;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bd_tick    (bd_tick),
    .rx         (rx),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Count status pulses away from the active edge
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bd_tick = ((cyc % 4) == 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},   {24'd0, data_out}, {24'd0, exp_data});
    chk({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, exp_valid});
    chk({tag, ".frame_errs"}, ferr_cnt, exp_ferr);
    chk({tag, ".overruns"},   ovr_cnt, exp_ovr);
  endtask

  // Drive one frame (optionally truncated); ack_at is the in-frame cycle at
  // which data_ack is high for one clock (-1 for none)
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int ack_at, input int cut, input int gap);
    logic [9:0] bits;
    logic       dv_prev;
    bits = {stop_b, d, 1'b0};
    while ((cyc % 4) != 0) step();
    dv_prev = data_valid;
    for (int idx = 0; idx < cut; idx++) begin
      rx       = bits[idx / BIT_CLK];
      data_ack = (idx == ack_at);
      step();
      if (data_valid && !dv_prev && rise_idx < 0) rise_idx = idx;
      dv_prev = data_valid;
    end
    data_ack = 1'b0;
    rx       = 1'b1;
    for (int i = 0; i < gap; i++) step();
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic ack_c);
    if (stop_b) begin
      if (exp_valid && !ack_c) exp_ovr++;
      exp_data  = d;
      exp_valid = 1'b1;
    end else begin
      exp_ferr++;
      if (ack_c) exp_valid = 1'b0;
    end
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    step();
    data_ack  = 1'b0;
    exp_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_b;
    int         mode;

    rst       = 1'b1;
    rx        = 1'b1;
    bd_tick   = 1'b0;
    data_ack  = 1'b0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ferr  = 0;
    exp_ovr   = 0;
    repeat (4) step();
    chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset.overrun",   {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (20) step();
    check_all("reset");

    // Plain frame, held until acknowledged
    send_frame(8'h55, 1'b1, -1, FRAME_CLK, 128);
    model_frame(8'h55, 1'b1, 1'b0);
    chk("latency_window", {31'd0, (rise_idx >= 600 && rise_idx <= 630)}, 32'd1);
    check_all("f55");
    repeat (200) step();
    chk("f55.hold_valid", {31'd0, data_valid}, 32'd1);
    do_ack();
    check_all("f55_ack");
    do_ack();
    check_all("ack_idle");

    // False start: line low for 3 ticks only
    while ((cyc % 4) != 0) step();
    rx = 1'b0;
    repeat (12) step();
    rx = 1'b1;
    repeat (128) step();
    check_all("false_start");

    // Bad stop bit
    send_frame(8'hA3, 1'b0, -1, FRAME_CLK, 128);
    model_frame(8'hA3, 1'b0, 1'b0);
    check_all("ferr_a3");

    // Back-to-back frames without ack
    send_frame(8'h01, 1'b1, -1, FRAME_CLK, 0);
    model_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, -1, FRAME_CLK, 128);
    model_frame(8'hFF, 1'b1, 1'b0);
    check_all("overrun");

    // Ack in the completion cycle while the old word is still valid
    send_frame(8'h3C, 1'b1, rise_idx, FRAME_CLK, 128);
    model_frame(8'h3C, 1'b1, 1'b1);
    check_all("ack_same_cycle");

    // Reset during bit 4 of a frame, then a clean frame
    send_frame(8'h81, 1'b1, -1, 5 * BIT_CLK + 30, 0);
    rst = 1'b1;
    step();
    step();
    rst       = 1'b0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    check_all("mid_reset");
    repeat (100) step();
    check_all("post_reset_idle");
    send_frame(8'hC3, 1'b1, -1, FRAME_CLK, 128);
    model_frame(8'hC3, 1'b1, 1'b0);
    check_all("after_reset");

    // Random frames: mode 0 no ack, 1 ack in completion cycle, 2 ack after
    for (int n = 0; n < 16; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      mode   = int'($urandom_range(0, 2));
      send_frame(d, stop_b, (mode == 1) ? rise_idx : -1, FRAME_CLK,
                 100 + int'($urandom_range(0, 60)));
      model_frame(d, stop_b, (mode == 1));
      check_all("rand");
      if (mode == 2) begin
        do_ack();
        check_all("rand_ack");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_uart_rx
